// File: rtl/trng_ctrl_if.sv
// Output word channel of the TRNG controller: a word plus valid/ready handshake.
interface trng_ctrl_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/trng_ctrl.sv
// Sequencing controller for the ring-oscillator entropy combiner: warm-up,
// pipeline flush, decimated sampling into words, valid/ready output and a
// sticky repetition-count health test.
module trng_ctrl #(
  parameter int WORD_WIDTH    = 32,
  parameter int WARMUP_CYCLES = 64,
  parameter int PIPE_LATENCY  = 6,
  parameter int SAMPLE_DIV    = 4,
  parameter int REP_LIMIT     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        raw_bit,
  output logic        ro_enable,
  output logic        busy,
  output logic        health_fail,
  trng_ctrl_if.master dout
);

  localparam int TMR_MAX = (WARMUP_CYCLES > PIPE_LATENCY) ? WARMUP_CYCLES : PIPE_LATENCY;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int DIV_W   = $clog2(SAMPLE_DIV) + 1;
  localparam int SAMP_W  = $clog2(WORD_WIDTH) + 1;
  localparam int REP_W   = $clog2(REP_LIMIT) + 1;

  localparam logic [TMR_W-1:0]  WARM_LAST  = TMR_W'(WARMUP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  FLUSH_LAST = TMR_W'(PIPE_LATENCY - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [SAMP_W-1:0] SAMP_LAST  = SAMP_W'(WORD_WIDTH - 1);
  localparam logic [REP_W-1:0]  REP_HIT    = REP_W'(REP_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE, S_WARMUP, S_FLUSH, S_COLLECT, S_HOLD, S_FAIL
  } state_t;

  state_t                  state_q, state_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [SAMP_W-1:0]       samp_q, samp_d;
  logic [REP_W-1:0]        rep_q, rep_d;
  logic                    prev_q, prev_d;
  logic                    has_prev_q, has_prev_d;
  logic [WORD_WIDTH-1:0]   shift_q, shift_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ro_en_q, ro_en_d;
  logic                    busy_q, busy_d;
  logic                    fail_q, fail_d;
  logic                    take;
  logic                    go_idle;

  // Next state, sample capture, health test and registered output values.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    div_d      = div_q;
    samp_d     = samp_q;
    rep_d      = rep_q;
    prev_d     = prev_q;
    has_prev_d = has_prev_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    take       = 1'b0;
    go_idle    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_WARMUP;
          tmr_d   = '0;
        end
      end
      S_WARMUP: begin
        if (!run) go_idle = 1'b1;
        else if (tmr_q == WARM_LAST) begin
          state_d = S_FLUSH;
          tmr_d   = '0;
        end else tmr_d = tmr_q + TMR_W'(1);
      end
      // The edge that ends the flush is also the first capture edge.
      S_FLUSH: begin
        if (!run) go_idle = 1'b1;
        else if (tmr_q == FLUSH_LAST) begin
          state_d = S_COLLECT;
          tmr_d   = '0;
          div_d   = '0;
          take    = 1'b1;
        end else tmr_d = tmr_q + TMR_W'(1);
      end
      S_COLLECT: begin
        if (!run) go_idle = 1'b1;
        else if (div_q == DIV_LAST) begin
          div_d = '0;
          take  = 1'b1;
        end else div_d = div_q + DIV_W'(1);
      end
      S_HOLD: begin
        if (valid_q && dout.data_ready) begin
          valid_d = 1'b0;
          if (run) begin
            state_d = S_COLLECT;
            div_d   = '0;
          end else go_idle = 1'b1;
        end
      end
      S_FAIL: ;
      default: go_idle = 1'b1;
    endcase

    // Leaving for IDLE drops the partial word and the repetition history.
    if (go_idle) begin
      state_d    = S_IDLE;
      tmr_d      = '0;
      div_d      = '0;
      samp_d     = '0;
      rep_d      = '0;
      prev_d     = 1'b0;
      has_prev_d = 1'b0;
      shift_d    = '0;
    end

    // Capture: health test has priority over word completion.
    if (take) begin
      shift_d    = {shift_q[WORD_WIDTH-2:0], raw_bit};
      rep_d      = (has_prev_q && (raw_bit == prev_q)) ? rep_q + REP_W'(1) : REP_W'(1);
      prev_d     = raw_bit;
      has_prev_d = 1'b1;
      if (rep_d == REP_HIT) begin
        state_d = S_FAIL;
        valid_d = 1'b0;
      end else if (samp_q == SAMP_LAST) begin
        data_d  = shift_d;
        valid_d = 1'b1;
        samp_d  = '0;
        state_d = S_HOLD;
      end else samp_d = samp_q + SAMP_W'(1);
    end

    ro_en_d = (state_d == S_WARMUP) || (state_d == S_FLUSH) ||
              (state_d == S_COLLECT) || (state_d == S_HOLD);
    busy_d  = ro_en_d;
    fail_d  = (state_d == S_FAIL);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      div_q      <= '0;
      samp_q     <= '0;
      rep_q      <= '0;
      prev_q     <= 1'b0;
      has_prev_q <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ro_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      div_q      <= div_d;
      samp_q     <= samp_d;
      rep_q      <= rep_d;
      prev_q     <= prev_d;
      has_prev_q <= has_prev_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ro_en_q    <= ro_en_d;
      busy_q     <= busy_d;
      fail_q     <= fail_d;
    end
  end

  assign ro_enable       = ro_en_q;
  assign busy            = busy_q;
  assign health_fail     = fail_q;
  assign dout.data_out   = data_q;
  assign dout.data_valid = valid_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Bench for trng_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a timestamp/queue model.
module tb_trng_ctrl;
  localparam int W    = 8;
  localparam int WARM = 4;
  localparam int PL   = 3;
  localparam int DIV  = 1;
  localparam int REP  = 5;

  localparam int P_IDLE = 0, P_ACT = 1, P_HOLD = 2, P_FAIL = 3;

  logic clock = 1'b0;
  logic reset, run, raw_bit, ready;
  logic ro_enable, busy, health_fail;

  trng_ctrl_if #(.WORD_WIDTH(W)) bus ();
  assign bus.data_ready = ready;

  trng_ctrl #(
    .WORD_WIDTH(W), .WARMUP_CYCLES(WARM), .PIPE_LATENCY(PL),
    .SAMPLE_DIV(DIV), .REP_LIMIT(REP)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .raw_bit(raw_bit),
    .ro_enable(ro_enable), .busy(busy), .health_fail(health_fail),
    .dout(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // model: phase, absolute edge of next sample, collected bits, run length
  int       t = 0;
  int       m_phase = P_IDLE;
  int       m_next = 0;
  bit       m_bits[$];
  bit       m_prev = 1'b0;
  bit       m_has_prev = 1'b0;
  int       m_runlen = 0;
  bit       m_valid = 1'b0;
  bit [W-1:0] m_data = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, t, got, exp);
    end
  endtask

  task automatic model_idle();
    m_phase = P_IDLE;
    m_bits.delete();
    m_has_prev = 1'b0;
    m_runlen = 0;
  endtask

  task automatic model_step();
    bit [W-1:0] w;
    if (reset) begin
      model_idle();
      m_valid = 1'b0;
      m_data  = '0;
    end else begin
      case (m_phase)
        P_IDLE: if (run) begin
          m_phase = P_ACT;
          m_next  = t + WARM + PL;
        end
        P_ACT: begin
          if (!run) model_idle();
          else if (t == m_next) begin
            m_runlen = (m_has_prev && raw_bit == m_prev) ? m_runlen + 1 : 1;
            m_prev = raw_bit;
            m_has_prev = 1'b1;
            m_bits.push_back(raw_bit);
            if (m_runlen >= REP) begin
              m_phase = P_FAIL;
              m_valid = 1'b0;
            end else if (m_bits.size() == W) begin
              w = '0;
              foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
              m_data  = w;
              m_valid = 1'b1;
              m_phase = P_HOLD;
              m_bits.delete();
            end else m_next = t + DIV;
          end
        end
        P_HOLD: if (ready) begin
          m_valid = 1'b0;
          if (run) begin
            m_phase = P_ACT;
            m_next  = t + DIV;
          end else model_idle();
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    bit act;
    act = (m_phase == P_ACT) || (m_phase == P_HOLD);
    chk("ro_enable",   {31'd0, ro_enable},      {31'd0, act});
    chk("busy",        {31'd0, busy},           {31'd0, act});
    chk("health_fail", {31'd0, health_fail},    {31'd0, m_phase == P_FAIL});
    chk("data_valid",  {31'd0, bus.data_valid}, {31'd0, m_valid});
    chk("data_out",    {24'd0, bus.data_out},   {24'd0, m_data});
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
    t++;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; ready = 1'b0; raw_bit = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ro_enable",   {31'd0, ro_enable},      32'd0);
    chk("rst_data_valid",  {31'd0, bus.data_valid}, 32'd0);
    chk("rst_data_out",    {24'd0, bus.data_out},   32'd0);
    chk("rst_health_fail", {31'd0, health_fail},    32'd0);
    chk("rst_busy",        {31'd0, busy},           32'd0);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; ready = 1'b0; raw_bit = 1'b0;

    // 1: startup timing, alternating bits from edge 7
    do_reset();
    for (int e = 0; e < 16; e++) begin
      run = 1'b1; ready = 1'b1; raw_bit = e[0];
      tick();
      if (e == 0)  chk("t1_ro_en_edge0", {31'd0, ro_enable}, 32'd1);
      if (e == 13) chk("t1_valid_e13", {31'd0, bus.data_valid}, 32'd0);
      if (e == 14) begin
        chk("t1_valid_e14", {31'd0, bus.data_valid}, 32'd1);
        chk("t1_data_e14", {24'd0, bus.data_out}, 32'hAA);
      end
      if (e == 15) chk("t1_valid_e15", {31'd0, bus.data_valid}, 32'd0);
    end

    // 2: backpressure for 20 cycles, then next word 8 cycles after handshake
    do_reset();
    for (int e = 0; e < 44; e++) begin
      run = 1'b1; ready = (e >= 35); raw_bit = e[0];
      tick();
      if (e > 14 && e < 35) begin
        chk("t2_hold_valid", {31'd0, bus.data_valid}, 32'd1);
        chk("t2_hold_data", {24'd0, bus.data_out}, 32'hAA);
      end
      if (e == 42) chk("t2_valid_e42", {31'd0, bus.data_valid}, 32'd0);
      if (e == 43) begin
        chk("t2_valid_e43", {31'd0, bus.data_valid}, 32'd1);
        chk("t2_data_e43", {24'd0, bus.data_out}, 32'h55);
      end
    end

    // 3: constant ones trip the health test at edge 11; run is ignored after
    do_reset();
    for (int e = 0; e < 24; e++) begin
      run = (e <= 11) ? 1'b1 : e[0]; ready = 1'b1; raw_bit = (e >= 7);
      tick();
      if (e == 10) chk("t3_fail_e10", {31'd0, health_fail}, 32'd0);
      if (e == 11) begin
        chk("t3_fail_e11", {31'd0, health_fail}, 32'd1);
        chk("t3_ro_e11", {31'd0, ro_enable}, 32'd0);
      end
      if (e >= 11) chk("t3_sticky", {31'd0, health_fail}, 32'd1);
      chk("t3_no_valid", {31'd0, bus.data_valid}, 32'd0);
    end

    // 4: word 1,0,1,0,1,1,1,1 then a 1 on the next word fails
    do_reset();
    for (int e = 0; e < 20; e++) begin
      run = 1'b1; ready = 1'b1; raw_bit = (e >= 11) ? 1'b1 : e[0];
      tick();
      if (e == 14) begin
        chk("t4_valid_e14", {31'd0, bus.data_valid}, 32'd1);
        chk("t4_data_e14", {24'd0, bus.data_out}, 32'hAF);
      end
      if (e == 15) chk("t4_fail_e15", {31'd0, health_fail}, 32'd0);
      if (e == 16) chk("t4_fail_e16", {31'd0, health_fail}, 32'd1);
      if (e >= 15) chk("t4_no_word2", {31'd0, bus.data_valid}, 32'd0);
    end

    // 5: run dropped after 5 samples, re-asserted at edge 15
    do_reset();
    for (int e = 0; e < 31; e++) begin
      run = !(e >= 12 && e < 15); ready = 1'b1; raw_bit = e[0];
      tick();
      if (e == 12) begin
        chk("t5_ro_e12", {31'd0, ro_enable}, 32'd0);
        chk("t5_busy_e12", {31'd0, busy}, 32'd0);
      end
      if (e == 28) chk("t5_valid_e28", {31'd0, bus.data_valid}, 32'd0);
      if (e == 29) begin
        chk("t5_valid_e29", {31'd0, bus.data_valid}, 32'd1);
        chk("t5_data_e29", {24'd0, bus.data_out}, 32'h55);
      end
    end

    // 6: reset while a word is held
    do_reset();
    for (int e = 0; e < 16; e++) begin
      run = 1'b1; ready = 1'b0; raw_bit = e[0];
      tick();
    end
    chk("t6_valid_before", {31'd0, bus.data_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", {31'd0, bus.data_valid}, 32'd0);
    chk("t6_data", {24'd0, bus.data_out}, 32'd0);
    chk("t6_ro", {31'd0, ro_enable}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_fail", {31'd0, health_fail}, 32'd0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset   = (m_phase == P_FAIL) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 499) == 0);
      run     = ($urandom_range(0, 31) != 0);
      ready   = $urandom_range(0, 1);
      raw_bit = $urandom_range(0, 1);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trng_ctrl.md
Name: trng_ctrl

Overview:
Sequencing controller for the ring-oscillator entropy combiner.
- Drives the combiner enable and waits out oscillator warm-up and the XOR-tree pipeline flush.
- Decimates the combined raw bit stream and packs samples into words.
- Presents words on a valid/ready interface.
- Runs a continuous repetition-count health test and latches a sticky failure that shuts the oscillators down.

Parameters:
WORD_WIDTH, 32, bits per output word (>=2)
WARMUP_CYCLES, 64, cycles with oscillators enabled before flush begins (>=1)
PIPE_LATENCY, 6, combiner register depth (clog2(NUM_OF_RO)+1); flush cycles before first sample (>=1)
SAMPLE_DIV, 4, raw bit sampled once every SAMPLE_DIV cycles in COLLECT (>=1)
REP_LIMIT, 16, consecutive identical samples that trip the health test (>=2)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  level; 1 = generate words, 0 = stop
raw_bit  in  1  combined oscillator bit (output_comb of combiner)
ro_enable  out  1  enable to combiner
data_out  out  WORD_WIDTH  packed random word
data_valid  out  1  data_out holds a word
data_ready  in  1  consumer accepts word when data_valid&data_ready
busy  out  1  state not IDLE and not FAIL
health_fail  out  1  sticky health-test failure

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high. All outputs are registered.
- Reset (any state, mid-operation included) forces state IDLE.
  - ro_enable=0, data_valid=0, data_out=0, health_fail=0.
  - All counters and the shift register are cleared.
  - Any partial or pending word is discarded.
- States: IDLE, WARMUP, FLUSH, COLLECT, HOLD, FAIL.
- IDLE: ro_enable=0. run=1 at edge N -> WARMUP, with ro_enable=1 from edge N.
- WARMUP: lasts WARMUP_CYCLES cycles -> FLUSH.
- FLUSH: lasts PIPE_LATENCY cycles -> COLLECT.
- COLLECT timing:
  - The first sample is captured at edge N+WARMUP_CYCLES+PIPE_LATENCY.
  - Later samples follow every SAMPLE_DIV cycles. The divider restarts at 0 on every entry to COLLECT.
- COLLECT capture:
  - Shift register shifts left; the new bit enters bit 0, so the first sample ends in the MSB.
  - On the edge capturing sample WORD_WIDTH, the completed word is loaded into data_out, data_valid is set to 1, the sample count clears, and state -> HOLD.
- HOLD:
  - ro_enable stays 1; no samples are taken; data_out is stable.
  - On the handshake edge (data_valid&data_ready), data_valid=0 from that edge, state -> COLLECT with no re-flush and the divider restarted.
  - data_out keeps the last word after data_valid falls.
- Health test (every captured sample, COLLECT only):
  - rep_cnt counts the current run of equal samples. It resets to 1 when a sample differs from the previous one.
  - The first sample after IDLE or reset has no predecessor; it sets rep_cnt=1.
  - rep_cnt reaching REP_LIMIT -> FAIL on that edge.
  - rep_cnt and the previous sample persist across HOLD, so runs continue across word boundaries.
- FAIL:
  - ro_enable=0, data_valid=0, health_fail=1, busy=0.
  - Exit only by reset; run is ignored.
- Simultaneous events:
  - Failure on the sample that completes a word: FAIL wins; the word is not presented and data_valid stays 0.
  - run=0 in WARMUP, FLUSH or COLLECT: -> IDLE next edge, ro_enable=0, partial word and rep history discarded.
  - run=0 in HOLD: the word is still offered until the handshake; then -> IDLE instead of COLLECT.
  - run=0 and the handshake on the same edge in HOLD: -> IDLE.
- Counter widths: $clog2 of each parameter maximum plus 1. No wrap is reachable.

Test Plan:
Parameters for all scenarios: WORD_WIDTH=8, WARMUP_CYCLES=4, PIPE_LATENCY=3, SAMPLE_DIV=1, REP_LIMIT=5.
1. Startup timing: run=1 seen at edge 0, data_ready=1, raw_bit alternating 1,0,1,0 from edge 7 -> ro_enable=1 from edge 0; data_valid=1 after edge 14 with data_out=8'hAA; data_valid=0 after edge 15.
2. Backpressure: data_ready=0 for 20 cycles after the word -> data_valid held 1, data_out stable, no samples taken; data_ready=1 -> next word completes 8 cycles after the handshake.
3. Health fail: raw_bit held 1 from edge 7 -> FAIL at edge 11; health_fail=1, ro_enable=0, data_valid never 1; run toggling has no effect until reset.
4. Fail on final bit: samples 1,0,1,0,1,1,1,1 then next word's first sample 1 -> first word 8'hAF presented; FAIL on next word's first sample with no second word; confirms run history carries across words.
5. run dropped mid-COLLECT after 5 samples -> IDLE next edge, ro_enable=0, no word; re-assert run -> full WARMUP+FLUSH repeats, first sample 7 cycles later.
6. Reset asserted in HOLD with data_valid=1 -> next edge: data_valid=0, data_out=0, ro_enable=0, busy=0, health_fail=0.
